// File: rtl/toast_id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and selection for toast_alu.
// Also raises hazard stalls: load-use always, and every RAW against an in-flight writer when forwarding is off.
module toast_id_ex_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic [31:0] id_rs1_data_i,
    input  logic [31:0] id_rs2_data_i,
    input  logic [31:0] id_imm_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic [3:0]  id_alu_ctrl_i,
    input  logic        id_op1_pc_i,
    input  logic        id_op2_imm_i,
    input  logic        id_reg_wr_i,
    input  logic        id_mem_rd_i,
    input  logic        exmem_reg_wr_i,
    input  logic [4:0]  exmem_rd_addr_i,
    input  logic [31:0] exmem_result_i,
    input  logic        memwb_reg_wr_i,
    input  logic [4:0]  memwb_rd_addr_i,
    input  logic [31:0] memwb_result_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        hazard_stall_o,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_rs2_fwd_o,
    output logic [4:0]  ex_rd_addr_o,
    output logic        ex_reg_wr_o,
    output logic        ex_mem_rd_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_op1_o,
    output logic [31:0] alu_op2_o
);

    logic        valid_reg;
    logic [31:0] pc_reg;
    logic [4:0]  rs1_addr_reg;
    logic [4:0]  rs2_addr_reg;
    logic [31:0] rs1_data_reg;
    logic [31:0] rs2_data_reg;
    logic [31:0] imm_reg;
    logic [4:0]  rd_addr_reg;
    logic [3:0]  alu_ctrl_reg;
    logic        op1_pc_reg;
    logic        op2_imm_reg;
    logic        reg_wr_reg;
    logic        mem_rd_reg;

    logic        rs_match_ex;
    logic        load_use;
    logic        raw_stall;

    assign rs_match_ex = (rd_addr_reg != 5'd0) &&
                         ((rd_addr_reg == id_rs1_addr_i) || (rd_addr_reg == id_rs2_addr_i));
    assign load_use    = id_valid_i && valid_reg && mem_rd_reg && rs_match_ex;

    generate
        if (FWD_EN) begin : g_fwd_on
            assign raw_stall = 1'b0;
        end else begin : g_fwd_off
            logic rs_match_exmem;
            assign rs_match_exmem = (exmem_rd_addr_i != 5'd0) &&
                                    ((exmem_rd_addr_i == id_rs1_addr_i) ||
                                     (exmem_rd_addr_i == id_rs2_addr_i));
            assign raw_stall = id_valid_i &&
                               ((valid_reg && reg_wr_reg && rs_match_ex) ||
                                (exmem_reg_wr_i && rs_match_exmem));
        end
    endgenerate

    // A flush kills the ID instruction anyway, so holding upstream would only waste a cycle.
    assign hazard_stall_o = !rst_i && !flush_i && (load_use || raw_stall);

    logic [4:0]  src_addr [2];
    logic [31:0] src_data [2];
    logic [31:0] src_fwd  [2];

    assign src_addr[0] = rs1_addr_reg;
    assign src_addr[1] = rs2_addr_reg;
    assign src_data[0] = rs1_data_reg;
    assign src_data[1] = rs2_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic exmem_hit;
            logic memwb_hit;
            assign exmem_hit = FWD_EN && exmem_reg_wr_i && (exmem_rd_addr_i != 5'd0) &&
                               (exmem_rd_addr_i == src_addr[gi]);
            assign memwb_hit = FWD_EN && memwb_reg_wr_i && (memwb_rd_addr_i != 5'd0) &&
                               (memwb_rd_addr_i == src_addr[gi]);
            // The younger EX/MEM result wins over MEM/WB.
            assign src_fwd[gi] = exmem_hit ? exmem_result_i :
                                 memwb_hit ? memwb_result_i : src_data[gi];
        end
    endgenerate

    assign ex_valid_o   = valid_reg;
    assign ex_pc_o      = pc_reg;
    assign ex_rs2_fwd_o = src_fwd[1];
    assign ex_rd_addr_o = rd_addr_reg;
    assign ex_reg_wr_o  = valid_reg && reg_wr_reg;
    assign ex_mem_rd_o  = valid_reg && mem_rd_reg;
    assign alu_ctrl_o   = valid_reg ? alu_ctrl_reg : 4'd0;
    assign alu_op1_o    = !valid_reg ? 32'd0 : (op1_pc_reg  ? pc_reg  : src_fwd[0]);
    assign alu_op2_o    = !valid_reg ? 32'd0 : (op2_imm_reg ? imm_reg : src_fwd[1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg    <= 1'b0;
            pc_reg       <= '0;
            rs1_addr_reg <= '0;
            rs2_addr_reg <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            imm_reg      <= '0;
            rd_addr_reg  <= '0;
            alu_ctrl_reg <= '0;
            op1_pc_reg   <= 1'b0;
            op2_imm_reg  <= 1'b0;
            reg_wr_reg   <= 1'b0;
            mem_rd_reg   <= 1'b0;
        end else if (flush_i) begin
            valid_reg <= 1'b0;
        end else if (!stall_i) begin
            if (hazard_stall_o) begin
                valid_reg <= 1'b0;
            end else begin
                valid_reg    <= id_valid_i;
                pc_reg       <= id_pc_i;
                rs1_addr_reg <= id_rs1_addr_i;
                rs2_addr_reg <= id_rs2_addr_i;
                rs1_data_reg <= id_rs1_data_i;
                rs2_data_reg <= id_rs2_data_i;
                imm_reg      <= id_imm_i;
                rd_addr_reg  <= id_rd_addr_i;
                alu_ctrl_reg <= id_alu_ctrl_i;
                op1_pc_reg   <= id_op1_pc_i;
                op2_imm_reg  <= id_op2_imm_i;
                reg_wr_reg   <= id_reg_wr_i;
                mem_rd_reg   <= id_mem_rd_i;
            end
        end
    end

endmodule
